uart_tx_cfg: RTL

Parametrised, buffered UART transmitter: a FIFO of configurable depth feeds a serializer with selectable data width, parity mode and stop-bit count. It replaces the fixed 8N1 single-byte transmitter on the FPGA-to-host result path. Producers can burst results into it without waiting on each frame. Frames leave back-to-back with no idle gap while data is queued.

---
 rtl/uart_tx_cfg.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: a FIFO feeds a serializer with configurable data
// width, parity mode and stop-bit count. Queued frames leave back to back.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 60_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int IW       = $clog2(DATA_BITS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [AW-1:0]         wptr, rptr;
  logic [LW-1:0]         level_nx;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  shreg;
  logic                  par;
  logic                  push, pop, tx_nx, baud_end;

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) return ~(^d);
    return ^d;
  endfunction

  assign ready    = (level != LW'(FIFO_DEPTH));
  assign push     = valid && ready;
  assign baud_end = (cnt == CW'(BAUD_DIV - 1));

  always_comb begin
    level_nx = level;
    if (push && !pop)      level_nx = level + 1'b1;
    else if (!push && pop) level_nx = level - 1'b1;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    pop      = 1'b0;
    if (state != IDLE) cnt_nx = baud_end ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        if (level != '0 && tx_en) begin
          pop      = 1'b1;
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_nx = DATA;
          idx_nx   = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_nx   = '0;
            state_nx = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (baud_end) begin
          state_nx = STOP;
          idx_nx   = '0;
        end
      end
      STOP: begin
        // The bit index doubles as the stop-bit counter.
        if (baud_end) begin
          if (idx == IW'(STOP_BITS - 1)) begin
            idx_nx = '0;
            if (level != '0 && tx_en) begin
              pop      = 1'b1;
              state_nx = START;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // tx is registered, so it is derived from the state being entered.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg[idx_nx];
      PAR:     tx_nx = par;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      tx    <= tx_nx;
      level <= level_nx;
      busy  <= (level_nx != '0) || (state_nx != IDLE);
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
    if (pop) begin
      shreg <= mem[rptr];
      par   <= calc_par(mem[rptr]);
    end
  end

endmodule
